// File: rtl/uart_listen.sv
// uart_listen: captures bytes from uart_rx into a message buffer and keeps
// a running byte count, additive checksum and saturating error count.
module uart_listen #(
  parameter int         message_len    = 512,
  parameter int         timeout_cycles = 1024,
  parameter logic [7:0] term_char      = 8'h00,
  localparam int        cursor_bits    = $clog2(message_len)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_error,
  input  logic                   clear,
  input  logic [cursor_bits-1:0] rd_addr,
  output logic [7:0]             rd_data,
  output logic [cursor_bits:0]   count,
  output logic [31:0]            checksum,
  output logic [7:0]             error_count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int timer_bits = $clog2(timeout_cycles);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [timer_bits-1:0]  timer;
  logic [7:0]             mem [message_len];
  logic                   take;
  logic [cursor_bits-1:0] wr_addr;
  logic                   is_term;

  assign is_term = (rx_data == term_char);
  assign busy    = (state == RECV);
  assign done    = (state == DONE);

  // a byte is stored only when nothing of higher priority claims the cycle
  always_comb begin
    take    = 1'b0;
    wr_addr = '0;
    if (!clear && !rx_error && rx_valid && !is_term && state != DONE)
      take = 1'b1;
    if (state == RECV)
      wr_addr = count[cursor_bits-1:0];
  end

  always_ff @(posedge clock) begin
    if (take)
      mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      checksum    <= '0;
      error_count <= '0;
      overflow    <= 1'b0;
      rd_data     <= '0;
      timer       <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (clear) begin
        state       <= IDLE;
        count       <= '0;
        checksum    <= '0;
        error_count <= '0;
        overflow    <= 1'b0;
        timer       <= '0;
      end else if (rx_error) begin
        if (error_count != 8'hFF)
          error_count <= error_count + 8'd1;
        if (state == RECV)
          timer <= '0;
      end else begin
        case (state)
          RECV: begin
            if (rx_valid) begin
              if (is_term) begin
                state <= DONE;
              end else begin
                count    <= count + 1'b1;
                checksum <= checksum + {24'b0, rx_data};
                timer    <= '0;
                if (count == (cursor_bits+1)'(message_len - 1))
                  state <= DONE;
              end
            end else if (timer == timer_bits'(timeout_cycles - 1)) begin
              state <= DONE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DONE: begin
            if (rx_valid)
              overflow <= 1'b1;
          end
          // encoding 3 falls here and behaves as IDLE
          default: begin
            if (rx_valid && !is_term) begin
              count    <= (cursor_bits+1)'(1);
              checksum <= {24'b0, rx_data};
              timer    <= '0;
              state    <= RECV;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_listen.sv
// tb_uart_listen: randomized + directed stimulus, message-level reference
// model feeding a scoreboard that a separate monitor drains.
module tb_uart_listen;

  localparam int LEN  = 512;
  localparam int T    = 16;
  localparam int CB   = $clog2(LEN);
  localparam logic [7:0] TERM = 8'h00;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          rx_valid, rx_error, clear;
  logic [7:0]    rx_data;
  logic [CB-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [CB:0]   count;
  logic [31:0]   checksum;
  logic [7:0]    error_count;
  logic          busy, done, overflow;

  uart_listen #(
    .message_len(LEN),
    .timeout_cycles(T),
    .term_char(TERM)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_error(rx_error),
    .clear(clear),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .count(count),
    .checksum(checksum),
    .error_count(error_count),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cnt;
    logic [31:0] sum;
    int          errs;
    int          dcyc;
    int          fcyc;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t       expq[$];
  logic [7:0] rdq[$];
  logic       rd_issue = 1'b0;
  logic       rd_due   = 1'b0;

  // reference model: the message as a byte list plus a few flags
  logic [7:0] ref_mem [LEN];
  logic [7:0] q[$];
  bit         open, fin, ovf;
  int         errs, first, last_evt;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rd_due <= rd_issue;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    open = 0;
    fin  = 0;
    ovf  = 0;
    errs = 0;
    q.delete();
  endtask

  task automatic finish(input int d);
    exp_t x;
    logic [31:0] s;
    s = 0;
    foreach (q[i]) s += 32'(q[i]);
    x.cnt  = q.size();
    x.sum  = s;
    x.errs = errs;
    x.dcyc = d;
    x.fcyc = first;
    expq.push_back(x);
    fin = 1;
  endtask

  task automatic model(input bit v, input logic [7:0] b, input bit e,
                       input bit c);
    if (c) begin
      model_clear();
    end else if (e) begin
      if (errs < 255) errs++;
      if (open && !fin) last_evt = cyc;
    end else if (v) begin
      if (fin) begin
        ovf = 1;
      end else if (b == TERM) begin
        if (open) finish(cyc + 1);
      end else begin
        if (!open) begin
          open  = 1;
          first = cyc;
        end
        ref_mem[q.size()] = b;
        q.push_back(b);
        last_evt = cyc;
        if (q.size() == LEN) finish(cyc + 1);
      end
    end else if (open && !fin && cyc - last_evt == T) begin
      finish(cyc + 1);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit e,
                      input bit c);
    rx_valid = v;
    rx_data  = b;
    rx_error = e;
    clear    = c;
    model(v, b, e, c);
    @(posedge clock);
    #1;
    rx_valid = 0;
    rx_error = 0;
    clear    = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 8'h00, 0, 1);
  endtask

  task automatic read_byte(input int a);
    rd_addr  = CB'(a);
    rdq.push_back(ref_mem[a]);
    rd_issue = 1;
    idle(1);
    rd_issue = 0;
  endtask

  // monitor: drains the scoreboard whenever the DUT presents a result
  bit   prev_done = 0;
  int   bc = 0;
  exp_t mx;
  logic [7:0] mr;

  always @(negedge clock) begin
    if (reset_n) begin
      if (rd_due) begin
        if (rdq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_queue: got read with no expectation");
        end else begin
          mr = rdq.pop_front();
          chk("rd_data", 64'(rd_data), 64'(mr));
        end
      end
      if (done && !prev_done) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 want no done, cyc %0d",
                   cyc);
        end else begin
          mx = expq.pop_front();
          chk("count", 64'(count), 64'(mx.cnt));
          chk("checksum", 64'(checksum), 64'(mx.sum));
          chk("error_count", 64'(error_count), 64'(mx.errs));
          chk("done_cycle", 64'(cyc), 64'(mx.dcyc));
          chk("busy_cycles", 64'(bc), 64'(mx.dcyc - mx.fcyc - 1));
        end
        bc = 0;
      end else if (busy) begin
        bc++;
      end else if (!done) begin
        bc = 0;
      end
    end
    prev_done = done;
  end

  int n, g;
  logic [7:0] b;

  initial begin
    reset_n  = 0;
    rx_valid = 0;
    rx_error = 0;
    clear    = 0;
    rx_data  = 0;
    rd_addr  = 0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_checksum", 64'(checksum), 0);
    chk("rst_errors", 64'(error_count), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;

    // "Hello" + terminator
    send(8'h48); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    send(TERM);
    idle(1);
    chk("hello_done", 64'(done), 1);
    chk("hello_count", 64'(count), 5);
    chk("hello_sum", 64'(checksum), 64'h1F4);
    for (int i = 0; i < 5; i++) read_byte(i);

    // error strobe alongside a byte in RECV
    do_clear();
    send(8'h10); send(8'h20);
    step(1, 8'h55, 1, 0);
    idle(1);
    chk("err_count", 64'(error_count), 1);
    chk("err_bytecount", 64'(count), 2);
    send(TERM);
    idle(1);
    for (int i = 0; i < 3; i++) read_byte(i);

    // leading terminators, then clear together with a byte in DONE
    do_clear();
    send(TERM); send(TERM);
    chk("lead_busy", 64'(busy), 0);
    send(8'h42); send(TERM);
    idle(1);
    chk("lead_count", 64'(count), 1);
    read_byte(0);
    step(1, 8'h77, 0, 1);
    chk("clr_busy", 64'(busy), 0);
    chk("clr_done", 64'(done), 0);
    chk("clr_count", 64'(count), 0);
    chk("clr_overflow", 64'(overflow), 0);
    idle(1);
    chk("clr_dropped", 64'(count), 0);

    // idle timeout
    send(8'h41); idle(9);
    send(8'h41); idle(9);
    send(8'h41); idle(T + 4);
    chk("to_count", 64'(count), 3);
    chk("to_sum", 64'(checksum), 64'hC3);

    // full buffer, then one byte too many
    do_clear();
    repeat (LEN) send(8'h01);
    idle(1);
    send(8'h01);
    chk("full_overflow", 64'(overflow), 1);
    chk("full_count", 64'(count), LEN);
    chk("full_sum", 64'(checksum), LEN);
    read_byte(0); read_byte(LEN / 2); read_byte(LEN - 1);

    // error counter saturation
    repeat (300) step(0, 8'h00, 1, 0);
    chk("err_sat", 64'(error_count), 255);
    chk("err_sat_model", 64'(error_count), 64'(errs));

    // randomized messages
    for (int m = 0; m < 24; m++) begin
      do_clear();
      if ($urandom_range(0, 3) == 0) send(TERM);
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0)
          step($urandom_range(0, 1), 8'($urandom_range(0, 255)), 1, 0);
        b = 8'($urandom_range(1, 255));
        send(b);
        g = $urandom_range(0, 4);
        idle(g);
      end
      if ($urandom_range(0, 1) == 0) send(TERM);
      else idle(T + 2);
      idle(1);
      if ($urandom_range(0, 2) == 0) begin
        send(8'($urandom_range(0, 255)));
        chk("rand_overflow", 64'(overflow), 64'(ovf));
      end
      for (int i = 0; i < n; i++) read_byte(i);
    end

    // asynchronous reset in the middle of a message
    do_clear();
    send(8'h31); send(8'h32); send(8'h33);
    rd_addr = 1;
    idle(2);
    chk("pre_rst_count", 64'(count), 3);
    #2;
    reset_n = 0;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_checksum", 64'(checksum), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_rd_data", 64'(rd_data), 0);
    model_clear();
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    send(8'h58); send(8'h59); send(8'h5A); send(TERM);
    idle(1);
    for (int i = 0; i < 3; i++) read_byte(i);

    idle(5);
    chk("pending_results", 64'(expq.size()), 0);
    chk("pending_reads", 64'(rdq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
